// File: rtl/data_cache_top_if.sv
// Full-line, single-beat AXI-style channel between the L1 data cache (master)
// and the next memory level (slave).
interface data_cache_top_if;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [31:0]  axi_awaddr;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [511:0] axi_wdata;
    logic [63:0]  axi_wstrb;
    logic         axi_wlast;
    logic         axi_bvalid;
    logic         axi_bready;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [31:0]  axi_araddr;
    logic         axi_rvalid;
    logic         axi_rready;
    logic [511:0] axi_rdata;

    modport master (
        output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
               axi_bready, axi_arvalid, axi_araddr, axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
               axi_bready, axi_arvalid, axi_araddr, axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
    );
endinterface

// File: rtl/data_cache_top.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 64 lines of 512 bits.
// Hits are served combinationally; misses stall the CPU while the FSM evicts and refills.
module data_cache_top #(
    parameter int L1_DATA_LENGTH = 32,
    parameter int L2_DATA_LENGTH = 32,
    parameter int L3_DATA_LENGTH = 32,
    parameter int LINE_BITS      = 512,
    parameter int NUM_LINES      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      cpu_load_valid,
    input  logic [31:0]               cpu_load_addr,
    output logic [L1_DATA_LENGTH-1:0] cpu_load_data_out,
    output logic                      cpu_load_miss_detected,
    input  logic                      cpu_store_valid,
    input  logic [31:0]               cpu_store_addr,
    input  logic [L1_DATA_LENGTH-1:0] cpu_store_data_in,
    output logic                      cpu_store_miss_detected,
    data_cache_top_if.master          axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_WB_RESP,
        S_RD,
        S_RD_RESP
    } state_e;

    // Storage
    logic [LINE_BITS-1:0]      data_q [NUM_LINES];
    logic [19:0]               tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]      valid_q;
    logic [NUM_LINES-1:0]      dirty_q;

    // Miss handling state and registered bus outputs
    state_e                    state_q;
    logic [25:0]               miss_line_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      arvalid_q;
    logic [31:0]               awaddr_q;
    logic [31:0]               araddr_q;
    logic [LINE_BITS-1:0]      wdata_q;
    logic [L1_DATA_LENGTH-1:0] load_data_q;

    // Address decode and hit detection
    logic [5:0]                ld_idx;
    logic [5:0]                st_idx;
    logic [5:0]                vic_idx;
    logic [5:0]                ref_idx;
    logic [3:0]                ld_word;
    logic [3:0]                st_word;
    logic                      ld_hit;
    logic                      st_hit;
    logic                      idle;
    logic                      flush_now;
    logic                      load_serve;
    logic                      store_serve;
    logic                      start_miss;
    logic                      refill_en;
    logic                      aw_done;
    logic                      w_done;
    logic [31:0]               miss_addr;
    logic [LINE_BITS-1:0]      ld_line;
    logic [L1_DATA_LENGTH-1:0] ld_word_data;

    assign ld_idx  = cpu_load_addr[11:6];
    assign ld_word = cpu_load_addr[5:2];
    assign st_idx  = cpu_store_addr[11:6];
    assign st_word = cpu_store_addr[5:2];

    assign ld_hit = valid_q[ld_idx] && (tag_q[ld_idx] == cpu_load_addr[31:12]);
    assign st_hit = valid_q[st_idx] && (tag_q[st_idx] == cpu_store_addr[31:12]);

    assign idle      = (state_q == S_IDLE);
    assign flush_now = flush && idle;

    // Loads win the single port; a concurrent store is held off for a cycle.
    assign load_serve  = cpu_load_valid && ld_hit && idle && !flush_now;
    assign store_serve = cpu_store_valid && st_hit && idle && !flush_now && !cpu_load_valid;

    assign cpu_load_miss_detected  = cpu_load_valid && !load_serve;
    assign cpu_store_miss_detected = cpu_store_valid && !store_serve;

    assign start_miss = idle && !flush_now &&
                        ((cpu_load_valid && !ld_hit) ||
                         (cpu_store_valid && !cpu_load_valid && !st_hit));
    assign miss_addr  = cpu_load_valid ? cpu_load_addr : cpu_store_addr;
    assign vic_idx    = miss_addr[11:6];
    assign ref_idx    = miss_line_q[5:0];
    assign refill_en  = (state_q == S_RD_RESP) && axi.axi_rvalid;

    assign aw_done = !awvalid_q || axi.axi_awready;
    assign w_done  = !wvalid_q || axi.axi_wready;

    assign ld_line      = data_q[ld_idx];
    assign ld_word_data = ld_line[{ld_word, 5'd0} +: L1_DATA_LENGTH];

    assign cpu_load_data_out = load_serve ? ld_word_data : load_data_q;

    assign axi.axi_awvalid = awvalid_q;
    assign axi.axi_awaddr  = awaddr_q;
    assign axi.axi_wvalid  = wvalid_q;
    assign axi.axi_wdata   = wdata_q;
    assign axi.axi_wstrb   = '1;
    assign axi.axi_wlast   = wvalid_q;
    assign axi.axi_bready  = 1'b1;
    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_araddr  = araddr_q;
    assign axi.axi_rready  = 1'b1;

    // Byte-offset bits and the reserved hierarchy widths have no function here.
    logic unused_bits;
    assign unused_bits = ^{cpu_load_addr[1:0], cpu_store_addr[1:0],
                           L2_DATA_LENGTH == 32, L3_DATA_LENGTH == 32};

    // NOTE: the data and tag arrays have no reset; valid_q alone decides whether
    // their contents mean anything, so resetting them would only cost hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill_en) begin
                data_q[ref_idx] <= axi.axi_rdata;
                tag_q[ref_idx]  <= miss_line_q[25:6];
            end else if (store_serve) begin
                data_q[st_idx][{st_word, 5'd0} +: L1_DATA_LENGTH] <= cpu_store_data_in;
            end
        end
    end

    // NOTE: every register in this block uses <= so each branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_line_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (load_serve) begin
                load_data_q <= ld_word_data;
            end
            if (store_serve) begin
                dirty_q[st_idx] <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (flush_now) begin
                        valid_q <= '0;
                        dirty_q <= '0;
                    end else if (start_miss) begin
                        miss_line_q <= miss_addr[31:6];
                        if (valid_q[vic_idx] && dirty_q[vic_idx]) begin
                            state_q   <= S_WB;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= {tag_q[vic_idx], vic_idx, 6'b0};
                            wdata_q   <= data_q[vic_idx];
                        end else begin
                            state_q   <= S_RD;
                            arvalid_q <= 1'b1;
                            araddr_q  <= {miss_addr[31:6], 6'b0};
                        end
                    end
                end

                S_WB: begin
                    if (axi.axi_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (axi.axi_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state_q <= S_WB_RESP;
                    end
                end

                S_WB_RESP: begin
                    if (axi.axi_bvalid) begin
                        state_q   <= S_RD;
                        arvalid_q <= 1'b1;
                        araddr_q  <= {miss_line_q, 6'b0};
                    end
                end

                S_RD: begin
                    if (axi.axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_RD_RESP;
                    end
                end

                S_RD_RESP: begin
                    if (axi.axi_rvalid) begin
                        valid_q[ref_idx] <= 1'b1;
                        dirty_q[ref_idx] <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_top.sv
// Bench for data_cache_top: directed scenarios plus a randomized load/store run
// checked against a flat word-addressed memory model with a behavioural AXI slave.
module tb_data_cache_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cpu_load_valid = 1'b0;
    logic [31:0] cpu_load_addr = '0;
    logic [31:0] cpu_load_data_out;
    logic        cpu_load_miss_detected;
    logic        cpu_store_valid = 1'b0;
    logic [31:0] cpu_store_addr = '0;
    logic [31:0] cpu_store_data_in = '0;
    logic        cpu_store_miss_detected;

    data_cache_top_if axi_if ();

    data_cache_top dut (
        .clk                     (clk),
        .rst                     (rst),
        .flush                   (flush),
        .cpu_load_valid          (cpu_load_valid),
        .cpu_load_addr           (cpu_load_addr),
        .cpu_load_data_out       (cpu_load_data_out),
        .cpu_load_miss_detected  (cpu_load_miss_detected),
        .cpu_store_valid         (cpu_store_valid),
        .cpu_store_addr          (cpu_store_addr),
        .cpu_store_data_in       (cpu_store_data_in),
        .cpu_store_miss_detected (cpu_store_miss_detected),
        .axi                     (axi_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural next-level memory ----------------
    logic [511:0] mem [logic [25:0]];
    bit           slow_mem = 1'b0;
    bit           hold_r = 1'b0;
    int           aw_count = 0;
    int           w_count = 0;
    int           ar_count = 0;
    int           seq = 0;
    int           b_seq = 0;
    int           ar_seq = 0;
    logic [31:0]  last_awaddr = '0;
    logic [31:0]  last_araddr = '0;
    logic [511:0] last_wdata = '0;
    logic [63:0]  last_wstrb = '0;
    logic         last_wlast = 1'b0;

    // Initial memory image: zero below 0x10000, a hash pattern above.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a < 32'h0001_0000) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [511:0] line_read(input logic [25:0] la);
        logic [511:0] l;
        logic [3:0]   w;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 16; i++) begin
            w = i[3:0];
            l[i*32 +: 32] = init_word({la, w, 2'b00});
        end
        return l;
    endfunction

    initial begin : slave
        bit           aw_fire, w_fire, ar_fire, aw_done, w_done, b_pend, ar_done;
        int           b_wait, r_wait;
        logic [31:0]  aw_lat, ar_lat, wb_addr, rd_addr;
        logic [511:0] w_lat, wb_data;
        logic [63:0]  strb_lat;
        logic         last_lat;
        {aw_fire, w_fire, ar_fire, aw_done, w_done, b_pend, ar_done} = '0;
        b_wait = 0;
        r_wait = 0;
        axi_if.axi_awready = 1'b0;
        axi_if.axi_wready  = 1'b0;
        axi_if.axi_arready = 1'b0;
        axi_if.axi_bvalid  = 1'b0;
        axi_if.axi_rvalid  = 1'b0;
        axi_if.axi_rdata   = '0;
        forever begin
            @(negedge clk);
            #2;
            axi_if.axi_bvalid = 1'b0;
            axi_if.axi_rvalid = 1'b0;
            if (rst) begin
                {aw_fire, w_fire, ar_fire, aw_done, w_done, b_pend, ar_done} = '0;
                axi_if.axi_awready = 1'b0;
                axi_if.axi_wready  = 1'b0;
                axi_if.axi_arready = 1'b0;
                continue;
            end
            // Handshakes decided last cycle completed at the edge just passed.
            if (aw_fire) begin
                aw_done = 1'b1; wb_addr = aw_lat; aw_count++; last_awaddr = aw_lat;
            end
            if (w_fire) begin
                w_done = 1'b1; wb_data = w_lat; w_count++;
                last_wdata = w_lat; last_wstrb = strb_lat; last_wlast = last_lat;
            end
            if (ar_fire) begin
                ar_done = 1'b1; rd_addr = ar_lat; ar_count++; last_araddr = ar_lat;
                seq++; ar_seq = seq;
                r_wait = slow_mem ? $urandom_range(0, 3) : 0;
            end
            if (aw_done && w_done) begin
                mem[wb_addr[31:6]] = wb_data;
                aw_done = 1'b0; w_done = 1'b0; b_pend = 1'b1;
                b_wait = slow_mem ? $urandom_range(0, 3) : 0;
            end
            if (b_pend) begin
                if (b_wait == 0) begin
                    axi_if.axi_bvalid = 1'b1; b_pend = 1'b0; seq++; b_seq = seq;
                end else begin
                    b_wait--;
                end
            end
            if (ar_done && !hold_r) begin
                if (r_wait == 0) begin
                    checks++;
                    if (axi_if.axi_araddr !== rd_addr) begin
                        errors++;
                        $display("FAIL araddr_stable: araddr=%h at rvalid, accepted %h", axi_if.axi_araddr, rd_addr);
                    end
                    axi_if.axi_rvalid = 1'b1;
                    axi_if.axi_rdata  = line_read(rd_addr[31:6]);
                    ar_done = 1'b0;
                end else begin
                    r_wait--;
                end
            end
            axi_if.axi_awready = slow_mem ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_if.axi_wready  = slow_mem ? 1'($urandom_range(0, 1)) : 1'b1;
            axi_if.axi_arready = slow_mem ? 1'($urandom_range(0, 1)) : 1'b1;
            aw_fire  = axi_if.axi_awvalid && axi_if.axi_awready;
            w_fire   = axi_if.axi_wvalid && axi_if.axi_wready;
            ar_fire  = axi_if.axi_arvalid && axi_if.axi_arready;
            aw_lat   = axi_if.axi_awaddr;
            w_lat    = axi_if.axi_wdata;
            strb_lat = axi_if.axi_wstrb;
            last_lat = axi_if.axi_wlast;
            ar_lat   = axi_if.axi_araddr;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- CPU-side drivers ----------------
    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stall);
        bit ok = 1'b0;
        stall = 0;
        @(negedge clk);
        cpu_load_valid = 1'b1;
        cpu_load_addr  = a;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (!cpu_load_miss_detected) begin ok = 1'b1; break; end
            stall++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL load_timeout: addr=%h still stalled after 400 cycles, want completion", a);
        end
        d = cpu_load_data_out;
        @(negedge clk);
        cpu_load_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] v, output int stall);
        bit ok = 1'b0;
        stall = 0;
        @(negedge clk);
        cpu_store_valid   = 1'b1;
        cpu_store_addr    = a;
        cpu_store_data_in = v;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (!cpu_store_miss_detected) begin ok = 1'b1; break; end
            stall++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL store_timeout: addr=%h still stalled after 400 cycles, want completion", a);
        end
        @(negedge clk);
        cpu_store_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cpu_load_valid = 1'b1;
        cpu_load_addr  = 32'h1000;
        #1;
        checks++;
        if ({axi_if.axi_awvalid, axi_if.axi_wvalid, axi_if.axi_arvalid, axi_if.axi_wlast} !== 4'b0) begin
            errors++;
            $display("FAIL reset_valids: aw/w/ar/wlast=%b want 0000",
                     {axi_if.axi_awvalid, axi_if.axi_wvalid, axi_if.axi_arvalid, axi_if.axi_wlast});
        end
        checks++;
        if (axi_if.axi_awaddr !== 32'h0 || axi_if.axi_araddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: awaddr=%h araddr=%h want 0", axi_if.axi_awaddr, axi_if.axi_araddr);
        end
        checks++;
        if (axi_if.axi_wdata !== 512'h0) begin
            errors++;
            $display("FAIL reset_wdata: wdata[31:0]=%h want all zero", axi_if.axi_wdata[31:0]);
        end
        checks++;
        if (cpu_load_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data_out: got %h want 0", cpu_load_data_out);
        end
        checks++;
        if (cpu_load_miss_detected !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_miss: got %b want 1", cpu_load_miss_detected);
        end
        checks++;
        if (axi_if.axi_wstrb !== {64{1'b1}} || axi_if.axi_bready !== 1'b1 || axi_if.axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL reset_consts: wstrb=%h bready=%b rready=%b want all-ones,1,1",
                     axi_if.axi_wstrb, axi_if.axi_bready, axi_if.axi_rready);
        end
        cpu_load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_cold_load();
        logic [31:0] d;
        int st, aw0, ar0;
        aw0 = aw_count; ar0 = ar_count;
        do_load(32'h1000, d, st);
        checks++;
        if (st == 0) begin errors++; $display("FAIL cold_miss: stall=%0d want >0", st); end
        checks++;
        if (ar_count != ar0 + 1 || last_araddr !== 32'h1000) begin
            errors++;
            $display("FAIL cold_ar: reads=%0d araddr=%h want 1 read at 00001000", ar_count - ar0, last_araddr);
        end
        checks++;
        if (aw_count != aw0) begin errors++; $display("FAIL cold_no_wb: writebacks=%0d want 0", aw_count - aw0); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL cold_data: got %h want 00000000", d); end
    endtask

    task automatic test_store_hit();
        logic [31:0] d;
        int st, aw0, ar0;
        aw0 = aw_count; ar0 = ar_count;
        do_store(32'h1004, 32'hDEAD_BEEF, st);
        checks++;
        if (st != 0) begin errors++; $display("FAIL store_hit_stall: stall=%0d want 0", st); end
        do_load(32'h1004, d, st);
        checks++;
        if (st != 0 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_readback: data=%h stall=%0d want deadbeef stall 0", d, st);
        end
        checks++;
        if (aw_count != aw0 || ar_count != ar0) begin
            errors++;
            $display("FAIL store_no_axi: aw=%0d ar=%0d want 0 0", aw_count - aw0, ar_count - ar0);
        end
    endtask

    task automatic test_writeback();
        logic [31:0] d;
        logic [511:0] wd;
        int st, aw0;
        aw0 = aw_count;
        do_load(32'h2000, d, st);
        wd = last_wdata;
        checks++;
        if (aw_count != aw0 + 1 || last_awaddr !== 32'h1000) begin
            errors++;
            $display("FAIL wb_aw: writebacks=%0d awaddr=%h want 1 at 00001000", aw_count - aw0, last_awaddr);
        end
        checks++;
        if (wd[63:32] !== 32'hDEAD_BEEF || wd[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL wb_wdata: words1,0=%h,%h want deadbeef,00000000", wd[63:32], wd[31:0]);
        end
        checks++;
        if (last_wstrb !== {64{1'b1}} || last_wlast !== 1'b1) begin
            errors++;
            $display("FAIL wb_strb_last: wstrb=%h wlast=%b want all-ones,1", last_wstrb, last_wlast);
        end
        checks++;
        if (ar_seq <= b_seq || last_araddr !== 32'h2000) begin
            errors++;
            $display("FAIL wb_then_rd: ar_seq=%0d b_seq=%0d araddr=%h want ar after b at 00002000",
                     ar_seq, b_seq, last_araddr);
        end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL wb_load_data: got %h want 00000000", d); end
    endtask

    task automatic test_persist();
        logic [31:0] d;
        int st, aw0;
        aw0 = aw_count;
        do_load(32'h1004, d, st);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL persist_data: got %h want deadbeef", d); end
        checks++;
        if (aw_count != aw0 || last_araddr !== 32'h1000) begin
            errors++;
            $display("FAIL persist_axi: writebacks=%0d araddr=%h want 0, 00001000", aw_count - aw0, last_araddr);
        end
    endtask

    task automatic test_load_store_priority();
        logic [31:0] d;
        int st;
        @(negedge clk);
        cpu_load_valid    = 1'b1;
        cpu_load_addr     = 32'h1008;
        cpu_store_valid   = 1'b1;
        cpu_store_addr    = 32'h100C;
        cpu_store_data_in = 32'h1234_5678;
        #1;
        checks++;
        if (cpu_load_miss_detected !== 1'b0 || cpu_store_miss_detected !== 1'b1) begin
            errors++;
            $display("FAIL prio_miss: load_miss=%b store_miss=%b want 0 1",
                     cpu_load_miss_detected, cpu_store_miss_detected);
        end
        checks++;
        if (cpu_load_data_out !== 32'h0) begin
            errors++;
            $display("FAIL prio_load_data: got %h want 00000000", cpu_load_data_out);
        end
        @(negedge clk);
        cpu_load_valid = 1'b0;
        #1;
        checks++;
        if (cpu_store_miss_detected !== 1'b0) begin
            errors++;
            $display("FAIL prio_store_next: store_miss=%b want 0", cpu_store_miss_detected);
        end
        @(negedge clk);
        cpu_store_valid = 1'b0;
        do_load(32'h100C, d, st);
        checks++;
        if (d !== 32'h1234_5678 || st != 0) begin
            errors++;
            $display("FAIL prio_store_commit: data=%h stall=%0d want 12345678 stall 0", d, st);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int st, aw0, ar0;
        @(negedge clk);
        flush             = 1'b1;
        cpu_load_valid    = 1'b1;
        cpu_load_addr     = 32'h1000;
        cpu_store_valid   = 1'b1;
        cpu_store_addr    = 32'h1010;
        cpu_store_data_in = 32'hAAAA_5555;
        #1;
        checks++;
        if (cpu_load_miss_detected !== 1'b1 || cpu_store_miss_detected !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle_miss: load_miss=%b store_miss=%b want 1 1",
                     cpu_load_miss_detected, cpu_store_miss_detected);
        end
        @(negedge clk);
        flush = 1'b0; cpu_load_valid = 1'b0; cpu_store_valid = 1'b0;
        aw0 = aw_count; ar0 = ar_count;
        do_load(32'h100C, d, st);
        checks++;
        if (st == 0 || ar_count != ar0 + 1 || last_araddr !== 32'h1000) begin
            errors++;
            $display("FAIL flush_refill: stall=%0d reads=%0d araddr=%h want >0, 1, 00001000",
                     st, ar_count - ar0, last_araddr);
        end
        checks++;
        if (aw_count != aw0 || d !== 32'h0) begin
            errors++;
            $display("FAIL flush_discard: writebacks=%0d data=%h want 0, 00000000", aw_count - aw0, d);
        end
        do_load(32'h1004, d, st);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_persist: got %h want deadbeef", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int st, ar0;
        bit seen = 1'b0;
        ar0 = ar_count;
        hold_r = 1'b1;
        @(negedge clk);
        cpu_load_valid = 1'b1;
        cpu_load_addr  = 32'h3000;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #3;
            if (ar_count > ar0) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_ar: no read address accepted within 100 cycles"); end
        @(negedge clk);
        rst = 1'b1;
        cpu_load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (axi_if.axi_arvalid !== 1'b0 || axi_if.axi_awvalid !== 1'b0 || cpu_load_data_out !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: arvalid=%b awvalid=%b data_out=%h want 0 0 0",
                     axi_if.axi_arvalid, axi_if.axi_awvalid, cpu_load_data_out);
        end
        hold_r = 1'b0;
        do_load(32'h1004, d, st);
        checks++;
        if (st == 0 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rstmid_invalid: stall=%0d data=%h want >0, deadbeef", st, d);
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [logic [31:0]];
        logic [31:0] a, v, d, exp_v;
        logic [19:0] tg;
        logic [5:0]  ix;
        logic [3:0]  wd;
        int st;
        slow_mem = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tg = 20'h10 + 20'($urandom_range(0, 2));
            ix = 6'($urandom_range(0, 3));
            wd = 4'($urandom_range(0, 15));
            a  = {tg, ix, wd, 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                do_store(a, v, st);
                ref_mem[a] = v;
            end else begin
                exp_v = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
                do_load(a, d, st);
                checks++;
                if (d !== exp_v) begin
                    errors++;
                    $display("FAIL random_load: op=%0d addr=%h got %h want %h", k, a, d, exp_v);
                end
            end
        end
        slow_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_writeback();
        test_persist();
        test_load_store_priority();
        test_flush();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
